// File: rtl/axi_sub_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : axi_sub_mem_responder
//  Description : AXI subordinate memory model. Accepts AW/W and AR bursts on
//                struct channels, keeps a byte array, and returns B and R
//                responses. The write and read paths are independent FSMs,
//                each holding one outstanding burst.
//  Revision    : 1.0 - initial release
// ============================================================================

package axi_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } aw_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_t;
endpackage

module axi_sub_mem_responder #(
    parameter type         axi_aw_t   = axi_pkg::aw_t,
    parameter type         axi_w_t    = axi_pkg::w_t,
    parameter type         axi_b_t    = axi_pkg::b_t,
    parameter type         axi_ar_t   = axi_pkg::ar_t,
    parameter type         axi_r_t    = axi_pkg::r_t,
    parameter int unsigned MEM_BYTES  = 65536,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned DATA_BYTES = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  axi_aw_t i_axi_s_aw,
    input  logic    i_axi_s_awvalid,
    output logic    o_axi_s_awready,
    input  axi_w_t  i_axi_s_w,
    input  logic    i_axi_s_wvalid,
    output logic    o_axi_s_wready,
    output axi_b_t  o_axi_s_b,
    input  logic    i_axi_s_bready,
    output logic    o_axi_s_bvalid,
    input  axi_ar_t i_axi_s_ar,
    input  logic    i_axi_s_arvalid,
    output logic    o_axi_s_arready,
    output axi_r_t  o_axi_s_r,
    input  logic    i_axi_s_rready,
    output logic    o_axi_s_rvalid
);

    localparam int ADDR_W   = 32;
    localparam int ADDR_W1  = ADDR_W + 1;
    localparam int DATA_W   = DATA_BYTES * 8;
    localparam int NB       = DATA_BYTES;
    localparam int IDXW     = $clog2(MEM_BYTES);
    localparam int MAX_SIZE = $clog2(DATA_BYTES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    // Address of the beat following 'a' for the given burst shape.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0]        size,
                                                    input logic [7:0]        len,
                                                    input logic [1:0]        burst);
        logic [ADDR_W-1:0] step, aligned, incr, wrap_len, wrap_base;
        step      = ADDR_W'(1) << size;
        aligned   = a & ~(step - ADDR_W'(1));
        incr      = aligned + step;
        wrap_len  = (ADDR_W'(len) + ADDR_W'(1)) << size;
        wrap_base = a & ~(wrap_len - ADDR_W'(1));
        case (burst)
            2'b00:   next_addr = a;
            2'b10:   next_addr = ((incr - wrap_base) >= wrap_len) ? wrap_base : incr;
            default: next_addr = incr;   // INCR and the reserved encoding
        endcase
    endfunction

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] x, lo, hi;
        x  = {1'b0, a};
        lo = {1'b0, BASE_ADDR};
        hi = lo + ADDR_W1'(MEM_BYTES);
        return (x >= lo) && (x < hi);
    endfunction

    // Memory index of byte lane 0 of the bus word holding address 'a'.
    function automatic logic [IDXW-1:0] lane0_index(input logic [ADDR_W-1:0] a);
        return IDXW'(a - BASE_ADDR) & ~IDXW'(DATA_BYTES - 1);
    endfunction

    function automatic logic size_too_big(input logic [2:0] s);
        return 32'(s) > 32'(MAX_SIZE);
    endfunction

    logic [7:0] mem_q [0:MEM_BYTES-1];

    // ------------------------------------------------------------------ write
    wstate_t           wstate_q, wstate_d;
    axi_aw_t           waw_q, waw_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [8:0]        wbeat_q, wbeat_d;
    logic              werr_q, werr_d;
    logic              wsize_err_q, wsize_err_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    axi_b_t            b_q, b_d;

    logic              wr_fire;
    logic              wr_en;
    logic [IDXW-1:0]   wr_base;

    assign wr_fire = (wstate_q == W_DATA) && wready_q && i_axi_s_wvalid;
    assign wr_en   = wr_fire && !wsize_err_q && addr_in_range(waddr_q);
    assign wr_base = lane0_index(waddr_q);

    // Strobed byte writes into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < NB; j++) begin
                if (i_axi_s_w.strb[j]) begin
                    mem_q[wr_base + IDXW'(j)] <= i_axi_s_w.data[8*j +: 8];
                end
            end
        end
    end

    // Write FSM next state: accept AW, absorb W beats until WLAST, hold B.
    always_comb begin
        wstate_d    = wstate_q;
        waw_d       = waw_q;
        waddr_d     = waddr_q;
        wbeat_d     = wbeat_q;
        werr_d      = werr_q;
        wsize_err_d = wsize_err_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        b_d         = b_q;
        case (wstate_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (i_axi_s_awvalid && awready_q) begin
                    waw_d       = i_axi_s_aw;
                    waddr_d     = i_axi_s_aw.addr;
                    wbeat_d     = '0;
                    wsize_err_d = size_too_big(i_axi_s_aw.size);
                    werr_d      = size_too_big(i_axi_s_aw.size) || (i_axi_s_aw.burst == 2'b11);
                    awready_d   = 1'b0;
                    wready_d    = 1'b1;
                    wstate_d    = W_DATA;
                end
            end
            W_DATA: begin
                if (wr_fire) begin
                    wbeat_d = (wbeat_q == 9'h1FF) ? wbeat_q : wbeat_q + 9'd1;
                    waddr_d = next_addr(waddr_q, waw_q.size, waw_q.len, waw_q.burst);
                    if (!addr_in_range(waddr_q) ||
                        (i_axi_s_w.last != (wbeat_q == {1'b0, waw_q.len}))) begin
                        werr_d = 1'b1;
                    end
                    if (i_axi_s_w.last) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        b_d.id   = waw_q.id;
                        b_d.resp = werr_d ? RESP_SLVERR : RESP_OKAY;
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && i_axi_s_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: begin
                wstate_d = W_IDLE;
            end
        endcase
    end

    // Write FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q    <= W_IDLE;
            waw_q       <= '0;
            waddr_q     <= '0;
            wbeat_q     <= '0;
            werr_q      <= 1'b0;
            wsize_err_q <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            b_q         <= '0;
        end else begin
            wstate_q    <= wstate_d;
            waw_q       <= waw_d;
            waddr_q     <= waddr_d;
            wbeat_q     <= wbeat_d;
            werr_q      <= werr_d;
            wsize_err_q <= wsize_err_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            b_q         <= b_d;
        end
    end

    // ------------------------------------------------------------------- read
    rstate_t           rstate_q, rstate_d;
    axi_ar_t           rar_q, rar_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [7:0]        rbeat_q, rbeat_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    axi_r_t            r_q, r_d;

    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ok;
    logic              rd_bad_burst;
    logic [1:0]        rd_resp;
    logic [IDXW-1:0]   rd_base;
    logic [DATA_W-1:0] rd_data;

    // The beat being launched: beat 0 from the AR channel, otherwise the
    // successor of the beat currently on the bus. Reading the array here,
    // before the clock edge, gives pre-write data on a same-cycle collision.
    always_comb begin
        if (rstate_q == R_IDLE) begin
            rd_addr      = i_axi_s_ar.addr;
            rd_ok        = addr_in_range(i_axi_s_ar.addr) && !size_too_big(i_axi_s_ar.size);
            rd_bad_burst = (i_axi_s_ar.burst == 2'b11);
        end else begin
            rd_addr      = next_addr(raddr_q, rar_q.size, rar_q.len, rar_q.burst);
            rd_ok        = addr_in_range(rd_addr) && !size_too_big(rar_q.size);
            rd_bad_burst = (rar_q.burst == 2'b11);
        end
        rd_resp = (rd_ok && !rd_bad_burst) ? RESP_OKAY : RESP_SLVERR;
        rd_base = lane0_index(rd_addr);
        rd_data = '0;
        for (int j = 0; j < NB; j++) begin
            rd_data[8*j +: 8] = rd_ok ? mem_q[rd_base + IDXW'(j)] : 8'h00;
        end
    end

    // Read FSM next state: accept AR, then stream beats at full throughput.
    always_comb begin
        rstate_d  = rstate_q;
        rar_d     = rar_q;
        raddr_d   = raddr_q;
        rbeat_d   = rbeat_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        r_d       = r_q;
        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (i_axi_s_arvalid && arready_q) begin
                    rar_d     = i_axi_s_ar;
                    raddr_d   = rd_addr;
                    rbeat_d   = '0;
                    r_d.id    = i_axi_s_ar.id;
                    r_d.data  = rd_data;
                    r_d.resp  = rd_resp;
                    r_d.last  = (i_axi_s_ar.len == 8'd0);
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && i_axi_s_rready) begin
                    if (r_q.last) begin
                        rvalid_d  = 1'b0;
                        arready_d = 1'b1;
                        rstate_d  = R_IDLE;
                    end else begin
                        raddr_d  = rd_addr;
                        rbeat_d  = rbeat_q + 8'd1;
                        r_d.data = rd_data;
                        r_d.resp = rd_resp;
                        r_d.last = ((rbeat_q + 8'd1) == rar_q.len);
                    end
                end
            end
            default: begin
                rstate_d = R_IDLE;
            end
        endcase
    end

    // Read FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q  <= R_IDLE;
            rar_q     <= '0;
            raddr_q   <= '0;
            rbeat_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            r_q       <= '0;
        end else begin
            rstate_q  <= rstate_d;
            rar_q     <= rar_d;
            raddr_q   <= raddr_d;
            rbeat_q   <= rbeat_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            r_q       <= r_d;
        end
    end

    assign o_axi_s_awready = awready_q;
    assign o_axi_s_wready  = wready_q;
    assign o_axi_s_bvalid  = bvalid_q;
    assign o_axi_s_b       = b_q;
    assign o_axi_s_arready = arready_q;
    assign o_axi_s_rvalid  = rvalid_q;
    assign o_axi_s_r       = r_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_sub_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_sub_mem_responder
//  Description : Self-checking bench for axi_sub_mem_responder. A byte-array
//                reference model predicts B/R responses when stimulus is
//                issued; a monitor pops and compares on each handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sub_mem_responder;
    import axi_pkg::*;

    localparam int MEMB = 65536;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aw_t  aw;      logic awvalid = 1'b0; logic awready;
    w_t   w;       logic wvalid  = 1'b0; logic wready;
    b_t   b;       logic bready  = 1'b1; logic bvalid;
    ar_t  ar;      logic arvalid = 1'b0; logic arready;
    r_t   r;       logic rready  = 1'b1; logic rvalid;

    axi_sub_mem_responder #(
        .MEM_BYTES (MEMB),
        .BASE_ADDR (32'h0),
        .DATA_BYTES(8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_axi_s_aw     (aw),
        .i_axi_s_awvalid(awvalid),
        .o_axi_s_awready(awready),
        .i_axi_s_w      (w),
        .i_axi_s_wvalid (wvalid),
        .o_axi_s_wready (wready),
        .o_axi_s_b      (b),
        .i_axi_s_bready (bready),
        .o_axi_s_bvalid (bvalid),
        .i_axi_s_ar     (ar),
        .i_axi_s_arvalid(arvalid),
        .o_axi_s_arready(arready),
        .o_axi_s_r      (r),
        .i_axi_s_rready (rready),
        .o_axi_s_rvalid (rvalid)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [MEMB];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    b_t          exp_b_q [$];
    r_t          exp_r_q [$];

    int bhold      = 0;
    bit rand_ready = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Address of beat k, straight from the burst rules.
    function automatic longint beat_addr(input longint a, input int size, input int len,
                                         input int burst, input int k);
        longint step, total, aligned, lower;
        step    = longint'(1) << size;
        total   = longint'(len + 1) * step;
        aligned = a - (a % step);
        lower   = a - (a % total);
        if (k == 0 || burst == 0) return a;
        if (burst == 2) return lower + ((aligned - lower + longint'(k) * step) % total);
        return aligned + longint'(k) * step;
    endfunction

    // ---------------------------------------------------------------- drivers
    task automatic send_aw(input aw_t v);
        int n = 0;
        bit hs = 1'b0;
        aw = v; awvalid = 1'b1;
        while (!hs && n < 200) begin
            @(negedge clk); hs = awready;
            @(posedge clk); #1; n++;
        end
        awvalid = 1'b0;
        chk("aw_handshake", hs, 1'b1);
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic l);
        int n = 0;
        bit hs = 1'b0;
        if (rand_ready) repeat ($urandom_range(0, 2)) begin
            wvalid = 1'b0; @(posedge clk); #1;
        end
        w.data = d; w.strb = s; w.last = l; wvalid = 1'b1;
        while (!hs && n < 200) begin
            @(negedge clk); hs = wready;
            @(posedge clk); #1; n++;
        end
        wvalid = 1'b0;
        chk("w_handshake", hs, 1'b1);
    endtask

    task automatic send_ar(input ar_t v);
        int n = 0;
        bit hs = 1'b0;
        ar = v; arvalid = 1'b1;
        while (!hs && n < 200) begin
            @(negedge clk); hs = arready;
            @(posedge clk); #1; n++;
        end
        arvalid = 1'b0;
        chk("ar_handshake", hs, 1'b1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_b_q.size() + exp_r_q.size());
            exp_b_q.delete(); exp_r_q.delete();
        end
    endtask

    // Write burst with nbeats beats from wd/ws; WLAST on the final one.
    task automatic do_write(input int id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input int nbeats);
        aw_t    v;
        b_t     e;
        bit     err;
        longint a;
        err = (size > 3) || (burst == 3) || (nbeats != len + 1);
        for (int k = 0; k < nbeats; k++) begin
            a = beat_addr(longint'(addr), size, len, burst, k);
            if (a >= MEMB) err = 1'b1;
            else if (size <= 3) begin
                for (int j = 0; j < 8; j++)
                    if (ws[k][j]) ref_mem[int'(a - (a % 8)) + j] = wd[k][8*j +: 8];
            end
        end
        e.id = 4'(id); e.resp = err ? 2'b10 : 2'b00;
        exp_b_q.push_back(e);
        v.id = 4'(id); v.addr = addr; v.len = 8'(len); v.size = 3'(size); v.burst = 2'(burst);
        send_aw(v);
        for (int k = 0; k < nbeats; k++) send_w(wd[k], ws[k], k == nbeats - 1);
        wait_drain();
    endtask

    task automatic do_read(input int id, input logic [31:0] addr, input int len,
                           input int size, input int burst);
        ar_t    v;
        r_t     e;
        longint a;
        bit     ok;
        for (int k = 0; k <= len; k++) begin
            a  = beat_addr(longint'(addr), size, len, burst, k);
            ok = (a < MEMB) && (size <= 3);
            e.id = 4'(id);
            for (int j = 0; j < 8; j++) e.data[8*j +: 8] = ok ? ref_mem[int'(a - (a % 8)) + j] : 8'h00;
            e.resp = (ok && burst != 3) ? 2'b00 : 2'b10;
            e.last = (k == len);
            exp_r_q.push_back(e);
        end
        v.id = 4'(id); v.addr = addr; v.len = 8'(len); v.size = 3'(size); v.burst = 2'(burst);
        send_ar(v);
        wait_drain();
    endtask

    // Response-side ready generation: optional hold on bready, random/toggling modes.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (bhold > 0) begin
                bready = 1'b0; bhold--;
            end else begin
                bready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            rready = rand_ready ? ~rready : 1'b1;
        end
    end

    // ---------------------------------------------------------------- monitor
    b_t   prev_b;
    r_t   prev_r;
    logic prev_b_stall = 1'b0;
    logic prev_r_stall = 1'b0;

    // Compare every handshake against the queued prediction; check payload hold under stall.
    always @(negedge clk) begin
        b_t eb;
        r_t er;
        if (!rst_n) begin
            prev_b_stall = 1'b0;
            prev_r_stall = 1'b0;
        end else begin
            if (bvalid) begin
                if (prev_b_stall) chk("b_stable", b, prev_b);
                if (bready) begin
                    if (exp_b_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL b_unexpected actual=%0h required=none", b);
                    end else begin
                        eb = exp_b_q.pop_front();
                        chk("b_id", b.id, eb.id);
                        chk("b_resp", b.resp, eb.resp);
                    end
                end
            end
            prev_b_stall = bvalid && !bready;
            prev_b       = b;
            if (rvalid) begin
                if (prev_r_stall) chk("r_stable", r, prev_r);
                if (rready) begin
                    if (exp_r_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL r_unexpected actual=%0h required=none", r);
                    end else begin
                        er = exp_r_q.pop_front();
                        chk("r_id", r.id, er.id);
                        chk("r_data", r.data, er.data);
                        chk("r_resp", r.resp, er.resp);
                        chk("r_last", r.last, er.last);
                    end
                end
            end
            prev_r_stall = rvalid && !rready;
            prev_r       = r;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        int     len, size, burst, nb;
        logic [31:0] addr;
        aw = '0; w = '0; ar = '0;
        for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready",  wready,  1'b0);
        chk("rst_bvalid",  bvalid,  1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_rvalid",  rvalid,  1'b0);
        chk("rst_b", b, '0);
        chk("rst_r", r, '0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("awready_before_edge", awready, 1'b0);
        @(posedge clk); #1;
        chk("awready_after_release", awready, 1'b1);
        chk("arready_after_release", arready, 1'b1);

        // Known contents for the low 8 KB (long INCR bursts)
        for (int blk = 0; blk < 4; blk++) begin
            for (int k = 0; k < 256; k++) begin
                wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF;
            end
            do_write(blk, 32'(blk * 2048), 255, 3, 1, 256);
        end

        // INCR write at 0x100, data = beat index, then read back
        for (int k = 0; k < 4; k++) begin wd[k] = 64'(k); ws[k] = 8'hFF; end
        do_write(5, 32'h100, 3, 3, 1, 4);
        do_read(5, 32'h100, 3, 3, 1);

        // WRAP read: beats at 0x118, 0x100, 0x108, 0x110
        do_read(6, 32'h118, 3, 3, 2);

        // Strobe: lower four lanes only
        wd[0] = 64'h0; ws[0] = 8'hFF;
        do_write(1, 32'h0, 0, 3, 1, 1);
        wd[0] = 64'h1122334455667788; ws[0] = 8'h0F;
        do_write(2, 32'h0, 0, 3, 1, 1);
        do_read(2, 32'h0, 0, 3, 1);

        // Backpressure: bready held low, rready toggling
        rand_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF; end
        bhold = 12;
        do_write(7, 32'h400, 7, 3, 1, 8);
        do_read(7, 32'h400, 7, 3, 1);
        rand_ready = 1'b0;

        // Errors: out of range, early WLAST, oversize, reserved burst
        wd[0] = 64'hDEADBEEFCAFEF00D; ws[0] = 8'hFF;
        do_write(3, 32'h10000, 0, 3, 1, 1);
        do_read(3, 32'h0, 0, 3, 1);
        do_read(3, 32'h10000, 1, 3, 1);
        for (int k = 0; k < 4; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF; end
        do_write(4, 32'h300, 3, 3, 1, 2);
        do_read(4, 32'h300, 3, 3, 1);
        do_write(8, 32'h500, 1, 4, 1, 2);
        do_read(8, 32'h500, 1, 3, 1);
        do_read(9, 32'h500, 1, 4, 1);
        do_write(10, 32'h600, 1, 3, 3, 2);
        do_read(10, 32'h600, 1, 3, 3);

        // Reset in the middle of a write burst; the first beat stays applied
        for (int k = 0; k < 4; k++) begin wd[k] = 64'h0; ws[k] = 8'hFF; end
        do_write(11, 32'h200, 3, 3, 1, 4);
        begin
            aw_t v;
            v.id = 4'd12; v.addr = 32'h200; v.len = 8'd3; v.size = 3'd3; v.burst = 2'd1;
            send_aw(v);
            send_w(64'hA5A5_0123_4567_89AB, 8'hFF, 1'b0);
            for (int j = 0; j < 8; j++) ref_mem[32'h200 + j] = 8'(64'hA5A5_0123_4567_89AB >> (8*j));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_awready", awready, 1'b0);
        chk("midrst_wready",  wready,  1'b0);
        chk("midrst_bvalid",  bvalid,  1'b0);
        chk("midrst_rvalid",  rvalid,  1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_awready_release", awready, 1'b1);
        chk("midrst_wready_release",  wready,  1'b0);
        do_read(12, 32'h200, 1, 3, 1);

        // Randomised bursts
        rand_ready = 1'b1;
        for (int it = 0; it < 60; it++) begin
            burst = $urandom_range(0, 15) == 0 ? 3 : $urandom_range(0, 2);
            size  = $urandom_range(0, 15) == 0 ? 4 : $urandom_range(0, 3);
            if (burst == 2) len = (2 << $urandom_range(0, 2)) - 1;
            else            len = $urandom_range(0, 7);
            addr = ($urandom_range(0, 15) == 0) ? 32'h10000 + 32'($urandom_range(0, 255))
                                                : 32'($urandom_range(0, 32'h0FFF));
            if ($urandom_range(0, 1) == 1) begin
                nb = len + 1;
                for (int k = 0; k < nb; k++) begin
                    wd[k] = {$urandom, $urandom}; ws[k] = 8'($urandom);
                end
                do_write(int'($urandom_range(0, 15)), addr, len, size, burst, nb);
            end else begin
                do_read(int'($urandom_range(0, 15)), addr, len, size, burst);
            end
        end
        rand_ready = 1'b0;

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
